timer_interval_sequencer: RTL

Sequencer that drives the register write ports of one 32-bit counter/timer to play back a programmed list of down-count intervals. It runs the timer in oneshot mode and re-arms it for each slot. It sits between the host wishbone decode and the timer's reg_val/reg_cfg write ports, and observes the timer's stop_out. Typical uses are timed GPIO/event sequences without per-interval CPU intervention.

---
 rtl/timer_interval_sequencer.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/timer_interval_sequencer.sv
// Plays back a programmed list of oneshot down-count intervals on a 32-bit timer's register write ports.
// Optional sticky completion interrupt: define TIMER_SEQ_IRQ_EN.
module timer_interval_sequencer #(
    parameter int unsigned NSLOTS = 4,
    parameter int unsigned SLOT_W = 2
) (
    input  logic              clkin,
    input  logic              resetn,
    input  logic              slot_we_i,
    input  logic [SLOT_W-1:0] slot_idx_i,
    input  logic [31:0]       slot_di_i,
    input  logic [SLOT_W:0]   slot_len_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              irq_clr_i,
    input  logic              tmr_stop_i,
    output logic [3:0]        tmr_val_we_o,
    output logic [31:0]       tmr_val_do_o,
    output logic              tmr_cfg_we_o,
    output logic [31:0]       tmr_cfg_do_o,
    output logic              busy_o,
    output logic [SLOT_W-1:0] cur_slot_o,
    output logic              slot_done_o,
    output logic              seq_done_o,
    output logic              irq_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = SLOT_W + 1;
    localparam int unsigned BE_W   = 4;
    localparam logic [DATA_W-1:0] CFG_ARM = DATA_W'(32'h3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_DIS
    } state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   cur_slot_q, cur_slot_d;
    logic [SLOT_W-1:0]   last_q, last_d;
    logic [SLOT_W-1:0]   last_sel;
    logic                first_q, first_d;
    logic                kill_q, kill_d;
    logic [DATA_W-1:0]   slot_q [NSLOTS];
    logic [DATA_W-1:0]   slot_d [NSLOTS];
    logic [DATA_W-1:0]   cur_val;
    logic [DATA_W-1:0]   nxt_val;

    logic [BE_W-1:0]     val_we_q, val_we_d;
    logic [DATA_W-1:0]   val_do_q, val_do_d;
    logic                cfg_we_q, cfg_we_d;
    logic [DATA_W-1:0]   cfg_do_q, cfg_do_d;
    logic                busy_q, busy_d;
    logic                slot_done_q, slot_done_d;
    logic                seq_done_q, seq_done_d;

    // Effective last slot index: length 0 plays one slot, oversize lengths clamp to the table.
    always_comb begin
        if (slot_len_i == '0) begin
            last_sel = '0;
        end else if (slot_len_i > LEN_W'(NSLOTS)) begin
            last_sel = SLOT_W'(NSLOTS - 1);
        end else begin
            last_sel = SLOT_W'(slot_len_i - LEN_W'(1));
        end
    end

    // Slot table only accepts writes while idle so a running sequence sees a stable list.
    always_comb begin
        for (int i = 0; i < NSLOTS; i++) begin
            slot_d[i] = slot_q[i];
        end
        if (state_q == S_IDLE && slot_we_i) begin
            slot_d[slot_idx_i] = slot_di_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_slot_d  = cur_slot_q;
        last_d      = last_q;
        kill_d      = 1'b0;
        first_d     = 1'b0;
        cur_val     = slot_q[cur_slot_q];
        nxt_val     = '0;
        val_we_d    = '0;
        val_do_d    = '0;
        cfg_we_d    = 1'b0;
        cfg_do_d    = '0;
        busy_d      = 1'b0;
        slot_done_d = 1'b0;
        seq_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d    = S_LOAD;
                    cur_slot_d = '0;
                    last_d     = last_sel;
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    state_d = S_DIS;
                    kill_d  = 1'b1;
                end else if (cur_val != '0) begin
                    state_d = S_ARM;
                end else if (cur_slot_q == last_q) begin
                    state_d = S_IDLE;
                end else begin
                    cur_slot_d = cur_slot_q + SLOT_W'(1);
                end
            end
            S_ARM: begin
                if (abort_i) begin
                    state_d = S_DIS;
                    kill_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // The timer's stop flag is still stale in the first cycle after arming.
                if (abort_i) begin
                    state_d = S_DIS;
                    kill_d  = 1'b1;
                end else if (!first_q && tmr_stop_i) begin
                    state_d = S_DIS;
                end
            end
            S_DIS: begin
                if (kill_q || abort_i || cur_slot_q == last_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_LOAD;
                    cur_slot_d = cur_slot_q + SLOT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        first_d = (state_d == S_RUN) && (state_q != S_RUN);

        // Outputs are decoded from the next state so they register alongside it.
        busy_d  = (state_d != S_IDLE);
        nxt_val = slot_d[cur_slot_d];
        case (state_d)
            S_LOAD: begin
                if (nxt_val != '0) begin
                    val_we_d = '1;
                    val_do_d = nxt_val;
                end else if (cur_slot_d == last_d) begin
                    seq_done_d = 1'b1;
                end
            end
            S_ARM: begin
                cfg_we_d = 1'b1;
                cfg_do_d = CFG_ARM;
            end
            S_DIS: begin
                cfg_we_d = 1'b1;
                if (!kill_d) begin
                    slot_done_d = 1'b1;
                    seq_done_d  = (cur_slot_d == last_d);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cur_slot_q  <= '0;
            last_q      <= '0;
            first_q     <= 1'b0;
            kill_q      <= 1'b0;
            val_we_q    <= '0;
            val_do_q    <= '0;
            cfg_we_q    <= 1'b0;
            cfg_do_q    <= '0;
            busy_q      <= 1'b0;
            slot_done_q <= 1'b0;
            seq_done_q  <= 1'b0;
            for (int i = 0; i < NSLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cur_slot_q  <= cur_slot_d;
            last_q      <= last_d;
            first_q     <= first_d;
            kill_q      <= kill_d;
            val_we_q    <= val_we_d;
            val_do_q    <= val_do_d;
            cfg_we_q    <= cfg_we_d;
            cfg_do_q    <= cfg_do_d;
            busy_q      <= busy_d;
            slot_done_q <= slot_done_d;
            seq_done_q  <= seq_done_d;
            for (int i = 0; i < NSLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

`ifdef TIMER_SEQ_IRQ_EN
    logic irq_q, irq_d;

    // Completion sets the flag even when a clear arrives in the same cycle.
    always_comb begin
        irq_d = irq_q;
        if (seq_done_q) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    logic irq_clr_unused;

    assign irq_clr_unused = irq_clr_i;
    assign irq_o          = 1'b0;
`endif

    assign tmr_val_we_o = val_we_q;
    assign tmr_val_do_o = val_do_q;
    assign tmr_cfg_we_o = cfg_we_q;
    assign tmr_cfg_do_o = cfg_do_q;
    assign busy_o       = busy_q;
    assign cur_slot_o   = cur_slot_q;
    assign slot_done_o  = slot_done_q;
    assign seq_done_o   = seq_done_q;

endmodule
